// File: rtl/lcd_display.sv
// HD44780 16x2 character LCD driver (4-bit, write-only) for the binary number game.
// Runs the controller power-on init, then redraws level, time left and game state forever.
module lcd_display #(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_4MS   = 205000,
    parameter int unsigned T_100US = 5000,
    parameter int unsigned T_40US  = 2000,
    parameter int unsigned T_CLR   = 82000,
    parameter int unsigned T_1US   = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:7] level,
    input  logic [0:4] timeleft,
    input  logic [0:1] state,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [0:3] lcd_d,
    output logic       sf_ce0,
    output logic       init_done
);

    localparam int unsigned CW = $clog2(T_PWR + T_4MS + T_CLR + 64);

    localparam logic [2:0] S_PWR   = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_CFG   = 3'd2;
    localparam logic [2:0] S_SNAP  = 3'd3;
    localparam logic [2:0] S_ADDR1 = 3'd4;
    localparam logic [2:0] S_LINE1 = 3'd5;
    localparam logic [2:0] S_ADDR2 = 3'd6;
    localparam logic [2:0] S_LINE2 = 3'd7;

    localparam logic [127:0] TXT_READY = "READY           ";
    localparam logic [127:0] TXT_PLAY  = "PLAYING         ";
    localparam logic [127:0] TXT_WIN   = "WIN             ";
    localparam logic [127:0] TXT_OVER  = "GAME OVER       ";

    logic [2:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic          half_q, half_d;
    logic [7:0]    sh_lvl_q, sh_lvl_d;
    logic [4:0]    sh_tl_q, sh_tl_d;
    logic [1:0]    sh_st_q, sh_st_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [3:0]    d_q, d_d;
    logic          done_q, done_d;

    logic [CW-1:0] wait_c;
    logic [3:0]    lvl_h_c, lvl_t_c, lvl_o_c, tl_t_c, tl_o_c;
    logic [7:0]    lvl_r_c;
    logic [127:0]  line2_c;
    logic [7:0]    byte_c;
    logic [3:0]    nib_c;
    logic          nib_st_c;

    assign lcd_e     = e_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_d     = d_q;
    assign sf_ce0    = 1'b1;
    assign init_done = done_q;

    // Wait that follows the nibble currently being strobed
    always_comb begin
        wait_c = CW'(T_40US);
        if (st_q == S_INIT) begin
            case (idx_q)
                4'd0:    wait_c = CW'(T_4MS);
                4'd1:    wait_c = CW'(T_100US);
                default: wait_c = CW'(T_40US);
            endcase
        end else if (!half_q) begin
            wait_c = CW'(T_1US);
        end else if (st_q == S_CFG && idx_q == 4'd3) begin
            wait_c = CW'(T_CLR);
        end
    end

    // Decimal digits of the shadow values
    always_comb begin
        lvl_h_c = 4'd0;
        lvl_r_c = sh_lvl_q;
        if (sh_lvl_q >= 8'd200) begin
            lvl_h_c = 4'd2;
            lvl_r_c = sh_lvl_q - 8'd200;
        end else if (sh_lvl_q >= 8'd100) begin
            lvl_h_c = 4'd1;
            lvl_r_c = sh_lvl_q - 8'd100;
        end
        lvl_t_c = 4'(lvl_r_c / 8'd10);
        lvl_o_c = 4'(lvl_r_c % 8'd10);
        tl_t_c  = 4'(sh_tl_q / 5'd10);
        tl_o_c  = 4'(sh_tl_q % 5'd10);
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        half_d   = half_q;
        sh_lvl_d = sh_lvl_q;
        sh_tl_d  = sh_tl_q;
        sh_st_d  = sh_st_q;
        done_d   = done_q;
        line2_c  = TXT_READY;
        byte_c   = 8'h00;
        nib_c    = 4'h0;
        nib_st_c = 1'b0;

        case (st_q)
            S_PWR: begin
                if (cnt_q == CW'(T_PWR - 1)) begin
                    st_d   = S_INIT;
                    idx_d  = 4'd0;
                    half_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            S_SNAP: begin
                sh_lvl_d = level;
                sh_tl_d  = timeleft;
                sh_st_d  = state;
                st_d     = S_ADDR1;
                idx_d    = 4'd0;
                half_d   = 1'b0;
                cnt_d    = '0;
            end
            default: begin
                // Nibble strobe is cycles 0..14, then the post-nibble wait
                if (cnt_q == CW'(14) + wait_c) begin
                    cnt_d = '0;
                    if (st_q == S_INIT) begin
                        half_d = 1'b0;
                        if (idx_q == 4'd3) begin
                            st_d  = S_CFG;
                            idx_d = 4'd0;
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end else if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        idx_d  = idx_q + 4'd1;
                        case (st_q)
                            S_CFG: begin
                                if (idx_q == 4'd3) begin
                                    st_d   = S_SNAP;
                                    done_d = 1'b1;
                                end
                            end
                            S_ADDR1: begin
                                st_d  = S_LINE1;
                                idx_d = 4'd0;
                            end
                            S_LINE1: begin
                                if (idx_q == 4'd15) st_d = S_ADDR2;
                            end
                            S_ADDR2: begin
                                st_d  = S_LINE2;
                                idx_d = 4'd0;
                            end
                            default: begin
                                if (idx_q == 4'd15) st_d = S_SNAP;
                            end
                        endcase
                    end
                end
            end
        endcase

        case (sh_st_q)
            2'b01:   line2_c = TXT_PLAY;
            2'b10:   line2_c = TXT_WIN;
            2'b11:   line2_c = TXT_OVER;
            default: line2_c = TXT_READY;
        endcase

        // Byte for the nibble about to be (or being) strobed
        case (st_d)
            S_CFG: begin
                case (idx_d[1:0])
                    2'd0:    byte_c = 8'h28;
                    2'd1:    byte_c = 8'h06;
                    2'd2:    byte_c = 8'h0C;
                    default: byte_c = 8'h01;
                endcase
            end
            S_ADDR1: byte_c = 8'h80;
            S_ADDR2: byte_c = 8'hC0;
            S_LINE1: begin
                case (idx_d)
                    4'd0:    byte_c = "L";
                    4'd1:    byte_c = "V";
                    4'd2:    byte_c = "L";
                    4'd3:    byte_c = ":";
                    4'd4:    byte_c = 8'h30 + {4'h0, lvl_h_c};
                    4'd5:    byte_c = 8'h30 + {4'h0, lvl_t_c};
                    4'd6:    byte_c = 8'h30 + {4'h0, lvl_o_c};
                    4'd8:    byte_c = "T";
                    4'd9:    byte_c = "I";
                    4'd10:   byte_c = "M";
                    4'd11:   byte_c = "E";
                    4'd12:   byte_c = ":";
                    4'd13:   byte_c = 8'h30 + {4'h0, tl_t_c};
                    4'd14:   byte_c = 8'h30 + {4'h0, tl_o_c};
                    default: byte_c = " ";
                endcase
            end
            S_LINE2: byte_c = 8'(line2_c >> {4'd15 - idx_d, 3'b000});
            default: byte_c = 8'h00;
        endcase

        nib_c = half_d ? byte_c[3:0] : byte_c[7:4];
        if (st_d == S_INIT) nib_c = (idx_d == 4'd3) ? 4'h2 : 4'h3;
        nib_st_c = (st_d != S_PWR) && (st_d != S_SNAP);

        // Bus only changes when a new nibble starts; lcd_d holds otherwise
        d_d  = nib_st_c ? nib_c : d_q;
        rs_d = nib_st_c ? (st_d == S_LINE1 || st_d == S_LINE2) : rs_q;
        e_d  = nib_st_c && (cnt_d >= CW'(2)) && (cnt_d <= CW'(13));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= S_PWR;
            cnt_q    <= '0;
            idx_q    <= 4'd0;
            half_q   <= 1'b0;
            sh_lvl_q <= 8'd0;
            sh_tl_q  <= 5'd0;
            sh_st_q  <= 2'd0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            d_q      <= 4'h0;
            done_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            half_q   <= half_d;
            sh_lvl_q <= sh_lvl_d;
            sh_tl_q  <= sh_tl_d;
            sh_st_q  <= sh_st_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            d_q      <= d_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_lcd_display.sv
// Directed bench for lcd_display: reset, init nibbles, frame contents, snapshot and mid-strobe reset.
module tb_lcd_display;

    localparam int T_PWR   = 20;
    localparam int T_4MS   = 10;
    localparam int T_100US = 8;
    localparam int T_40US  = 6;
    localparam int T_CLR   = 12;
    localparam int T_1US   = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [0:7] level;
    logic [0:4] timeleft;
    logic [0:1] state;
    logic       lcd_e, lcd_rs, lcd_rw, sf_ce0, init_done;
    logic [0:3] lcd_d;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit dead   = 1'b0;

    logic [4:0] nq[$];
    int         tq[$];

    lcd_display #(
        .T_PWR(T_PWR), .T_4MS(T_4MS), .T_100US(T_100US),
        .T_40US(T_40US), .T_CLR(T_CLR), .T_1US(T_1US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .level(level), .timeleft(timeleft), .state(state),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d),
        .sf_ce0(sf_ce0), .init_done(init_done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Record {rs, nibble} and cycle number at every rising edge of lcd_e
    initial begin
        logic prev_e;
        prev_e = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                nq.push_back({lcd_rs, lcd_d});
                tq.push_back(cyc);
            end
            prev_e = lcd_e;
        end
    end

    task automatic wait_nib();
        int n;
        n = 0;
        while (nq.size() == 0 && n < 300 && !dead) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (nq.size() == 0) dead = 1'b1;
    endtask

    task automatic get_nib(output logic rs, output logic [3:0] d, output int t, output bit ok);
        rs = 1'b0; d = 4'h0; t = 0; ok = 1'b0;
        wait_nib();
        if (nq.size() != 0) begin
            {rs, d} = nq.pop_front();
            t  = tq.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic get_byte(output logic [1:0] rs, output logic [7:0] b, output int gap, output bit ok);
        logic r;
        logic [3:0] d;
        int t0, t1;
        bit ok0, ok1;
        get_nib(r, d, t0, ok0);
        rs[1] = r; b[7:4] = d;
        get_nib(r, d, t1, ok1);
        rs[0] = r; b[3:0] = d;
        gap = t1 - t0;
        ok  = ok0 && ok1;
    endtask

    task automatic test_reset();
        int rel;
        #1 rst_n = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            checks++;
            if ({lcd_e, lcd_rs, lcd_rw, lcd_d, sf_ce0, init_done} !== 9'b0_0_0_0000_1_0) begin
                errors++;
                $display("FAIL reset_values: e=%b rs=%b rw=%b d=%h ce0=%b done=%b, want 0 0 0 0 1 0",
                         lcd_e, lcd_rs, lcd_rw, lcd_d, sf_ce0, init_done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_nib();
        checks++;
        if (nq.size() == 0 || tq[0] != rel + T_PWR + 2) begin
            errors++;
            $display("FAIL first_strobe: at cycle %0d after release, want %0d",
                     (nq.size() == 0) ? -1 : tq[0] - rel, T_PWR + 2);
        end
    endtask

    task automatic test_init();
        int en[12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
        int eg[12] = '{0, 25, 23, 21, 21, 18, 21, 18, 21, 18, 21, 18};
        logic r;
        logic [3:0] d;
        int t, tprev;
        bit ok;
        tprev = 0;
        for (int i = 0; i < 12; i++) begin
            get_nib(r, d, t, ok);
            checks++;
            if (!ok || r !== 1'b0 || d !== 4'(en[i]) || (i > 0 && t - tprev != eg[i])) begin
                errors++;
                $display("FAIL init_nibble %0d: ok=%0d rs=%b d=%h gap=%0d, want rs=0 d=%h gap=%0d",
                         i, ok, r, d, t - tprev, 4'(en[i]), eg[i]);
            end
            tprev = t;
        end
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_done_early: got %b, want 0", init_done);
        end
        wait_nib();
        checks++;
        if (nq.size() == 0 || tq[0] - tprev != 15 + T_CLR + 1 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL init_done_rise: done=%b gap=%0d, want done=1 gap=%0d",
                     init_done, (nq.size() == 0) ? -1 : tq[0] - tprev, 15 + T_CLR + 1);
        end
    endtask

    task automatic test_frame(input string l1, input string l2, input int chg_at, input logic [7:0] chg_lvl);
        logic [1:0] rs;
        logic [7:0] b, eb;
        logic er;
        int gap;
        bit ok;
        for (int i = 0; i < 34; i++) begin
            if (i == 0) begin
                eb = 8'h80; er = 1'b0;
            end else if (i <= 16) begin
                eb = l1[i-1]; er = 1'b1;
            end else if (i == 17) begin
                eb = 8'hC0; er = 1'b0;
            end else begin
                eb = l2[i-18]; er = 1'b1;
            end
            get_byte(rs, b, gap, ok);
            if (i == chg_at) level = chg_lvl;
            checks++;
            if (!ok || rs !== {er, er} || b !== eb || gap != 15 + T_1US) begin
                errors++;
                $display("FAIL frame_byte %0d: ok=%0d rs=%b byte=%h gap=%0d, want rs=%b byte=%h gap=%0d",
                         i, ok, rs, b, gap, {er, er}, eb, 15 + T_1US);
            end
        end
    endtask

    task automatic test_extremes();
        level = 8'd255; timeleft = 5'd0; state = 2'b11;
        test_frame("LVL:255 TIME:00 ", "GAME OVER       ", -1, 8'd0);
    endtask

    task automatic test_snapshot();
        level = 8'd5; timeleft = 5'd17; state = 2'b01;
        test_frame("LVL:005 TIME:17 ", "PLAYING         ", 6, 8'd6);
        test_frame("LVL:006 TIME:17 ", "PLAYING         ", -1, 8'd0);
    endtask

    task automatic test_midstrobe();
        logic [1:0] rs;
        logic [7:0] b;
        logic r;
        logic [3:0] d;
        int gap, t, rel;
        bit ok;
        for (int i = 0; i < 20; i++) get_byte(rs, b, gap, ok);
        get_nib(r, d, t, ok);
        checks++;
        if (!ok || lcd_e !== 1'b1 || r !== 1'b1) begin
            errors++;
            $display("FAIL midstrobe_setup: ok=%0d e=%b rs=%b, want 1 1 1", ok, lcd_e, r);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (lcd_e !== 1'b0 || init_done !== 1'b0 || lcd_d !== 4'h0 || lcd_rs !== 1'b0) begin
            errors++;
            $display("FAIL midstrobe_abort: e=%b done=%b d=%h rs=%b, want 0 0 0 0",
                     lcd_e, init_done, lcd_d, lcd_rs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        nq.delete();
        tq.delete();
        dead = 1'b0;
        get_nib(r, d, t, ok);
        checks++;
        if (!ok || r !== 1'b0 || d !== 4'h3 || t != rel + T_PWR + 2) begin
            errors++;
            $display("FAIL midstrobe_restart: ok=%0d rs=%b d=%h at %0d, want rs=0 d=3 at %0d",
                     ok, r, d, t - rel, T_PWR + 2);
        end
    endtask

    initial begin
        level = 8'd5; timeleft = 5'd17; state = 2'b01;
        test_reset();
        test_init();
        test_frame("LVL:005 TIME:17 ", "PLAYING         ", -1, 8'd0);
        test_extremes();
        test_snapshot();
        test_midstrobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_display.md
# lcd_display

Character-LCD driver for the binary number game: the output side of the top level, which today only consumes switches and buttons. It drives a 16x2 HD44780-compatible LCD over its 4-bit write-only bus. After power-up it runs the controller init sequence, then continuously redraws two lines showing the current level, time left and game state, all taken from the game logic and timer outputs.

## Interface
- T_PWR, 750000: power-on wait in clk cycles (15 ms at 50 MHz)
- T_4MS, 205000: wait after first init nibble (4.1 ms)
- T_100US, 5000: wait after second init nibble
- T_40US, 2000: wait after third/fourth init nibble and after every byte
- T_CLR, 82000: wait after the clear-display byte (1.64 ms)
- T_1US, 50: gap between high and low nibble of a byte
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- level  in  [0:7]  current level, unsigned, bit 0 = MSB
- timeleft  in  [0:4]  seconds left, unsigned, bit 0 = MSB
- state  in  [0:1]  game state: 00 READY, 01 PLAYING, 10 WIN, 11 GAME OVER
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_d  out  [0:3]  data nibble, bit 0 = D7
- sf_ce0  out  1  StrataFlash disable, constant 1
- init_done  out  1  high once configuration is complete

## Operation
- Reset values (asynchronous, held while rst_n=0): lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0000, sf_ce0=1, init_done=0. The FSM is in PWR_WAIT and all counters are 0.
- PWR_WAIT: wait T_PWR cycles.
- INIT: write single nibbles 3, 3, 3, 2 with rs=0. Waits after each are T_4MS, T_100US, T_40US and T_40US respectively.
- CFG: write command bytes 28h, 06h, 0Ch, 01h. Wait T_40US after each, except T_CLR after 01h. init_done rises on the cycle CFG exits and stays high until reset.
- Frame loop:
  - SNAP: register level, timeleft and state into shadow copies. Input changes after SNAP are invisible until the next SNAP.
  - ADDR1: command 80h.
  - LINE1: 16 data bytes.
  - ADDR2: command C0h.
  - LINE2: 16 data bytes.
  - Return to SNAP, with no idle gap.
- Line 1 ASCII: "LVL:" + 3 decimal digits of level with leading zeros + " TIME:" + 2 decimal digits of timeleft with leading zeros + " ". Total 16 characters.
- Line 2 ASCII, space-padded to 16 characters: "READY", "PLAYING", "WIN" or "GAME OVER", selected by the shadow state.
- Binary-to-decimal conversion works on the shadow values only. Level covers 0..255. Timeleft covers 0..31, so its tens digit is never above 3.
- Byte write: send the high nibble (D7..D4), wait T_1US, send the low nibble, then apply the post-byte wait. rs is 1 for data bytes and 0 for commands.
- Reset asserted mid-operation aborts immediately, including mid-strobe: lcd_e drops to 0 asynchronously. After release the full sequence restarts from PWR_WAIT.

## Timing
- Nibble strobe, in cycles relative to the nibble start:
  - rs and lcd_d valid at cycle 0.
  - lcd_e high from cycle 2 to cycle 13 (12 cycles).
  - lcd_e low at cycle 14.
  - rs and lcd_d held stable through cycle 14.
- The post-nibble wait counts from the cycle after lcd_e falls.
- lcd_d and rs change only while lcd_e=0 and never within 2 cycles before a rising edge of lcd_e.
- Between nibbles, lcd_d holds its last value.
- Frame length is fixed: 34 bytes, each taking 15 + T_1US + 15 + T_40US cycles.
- SNAP takes exactly 1 cycle.
- First rs=1 strobe: follows PWR_WAIT, INIT, CFG and ADDR1, with all waits at their parameter values.

## Test plan
- Reset check: hold rst_n=0 for 10 cycles, then release with small parameters (T_PWR=20, T_4MS=10, T_100US=8, T_40US=6, T_CLR=12, T_1US=3). Required: all outputs at reset values during reset; first lcd_e rise exactly T_PWR+2 cycles after release.
- Init check: capture strobed nibbles. Required sequence is 3,3,3,2, then 2,8, 0,6, 0,C, 0,1, all with rs=0. Inter-strobe gaps must match the parameters. init_done rises after the 01h wait.
- Frame check with level=5, timeleft=17, state=01. Required: command 80h, then "LVL:005 TIME:17 ", then command C0h, then "PLAYING" plus 9 spaces.
- Extremes with level=255, timeleft=0, state=11. Required: "LVL:255 TIME:00 " and "GAME OVER" plus 7 spaces.
- Snapshot check: change level from 5 to 6 during LINE1 character 5. Required: the current frame still shows "005"; the next frame shows "006".
- Mid-strobe reset: assert rst_n=0 while lcd_e=1 during LINE2. Required: lcd_e=0 in the same cycle, init_done=0. After release, the nibble sequence restarts with 3 after T_PWR.
